// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: function codes and arbiter FSM states.
package alu_pkg;

    localparam logic [3:0] FunAdd  = 4'b0000;
    localparam logic [3:0] FunSub  = 4'b1000;
    localparam logic [3:0] FunOr   = 4'b0110;
    localparam logic [3:0] FunAnd  = 4'b0111;
    localparam logic [3:0] FunXor  = 4'b0100;
    localparam logic [3:0] FunSrl  = 4'b0101;
    localparam logic [3:0] FunSll  = 4'b0001;
    localparam logic [3:0] FunSra  = 4'b1101;
    localparam logic [3:0] FunSlt  = 4'b0010;
    localparam logic [3:0] FunSltu = 4'b0011;
    localparam logic [3:0] FunCopy = 4'b1001;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU; unknown function codes produce zero.
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ALU_FUN,
    output logic [31:0] ALU_OUT
);

    logic [4:0] shamt;
    assign shamt = B[4:0];

    always_comb begin
        ALU_OUT = 32'h0;
        case (ALU_FUN)
            FunAdd:  ALU_OUT = A + B;
            FunSub:  ALU_OUT = A - B;
            FunOr:   ALU_OUT = A | B;
            FunAnd:  ALU_OUT = A & B;
            FunXor:  ALU_OUT = A ^ B;
            FunSrl:  ALU_OUT = A >> shamt;
            FunSll:  ALU_OUT = A << shamt;
            FunSra:  ALU_OUT = $unsigned($signed(A) >>> shamt);
            FunSlt:  ALU_OUT = {31'h0, $signed(A) < $signed(B)};
            FunSltu: ALU_OUT = {31'h0, A < B};
            FunCopy: ALU_OUT = A;
            default: ALU_OUT = 32'h0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU; one operation in flight, registered response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_fun,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_fun,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_id
);

    arb_state_e  state_q, state_d;
    logic [31:0] a_q, b_q;
    logic [3:0]  fun_q;
    logic        id_q;
    logic        last_q;
    logic [31:0] rsp_data_q;
    logic        rsp_id_q;
    logic        gnt_valid, gnt_id, accept;
    logic [31:0] alu_out;

    // Tie goes to whoever did not win last; fixed priority always favours requester 0.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = RR_EN ? ~last_q : 1'b0;
        end else if (req0_valid) begin
            gnt_valid = 1'b1;
        end else if (req1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b1;
        end
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == StIdle && !RST && gnt_valid) begin
            req0_ready = ~gnt_id;
            req1_ready = gnt_id;
        end
        accept = req0_ready | req1_ready;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            a_q        <= 32'h0;
            b_q        <= 32'h0;
            fun_q      <= 4'h0;
            id_q       <= 1'b0;
            last_q     <= 1'b1;
            rsp_data_q <= 32'h0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q    <= gnt_id ? req1_a : req0_a;
                b_q    <= gnt_id ? req1_b : req0_b;
                fun_q  <= gnt_id ? req1_fun : req0_fun;
                id_q   <= gnt_id;
                last_q <= gnt_id;
            end
            if (state_q == StExec) begin
                rsp_data_q <= alu_out;
                rsp_id_q   <= id_q;
            end
        end
    end

    alu_arbiter_alu u_alu (
        .A       (a_q),
        .B       (b_q),
        .ALU_FUN (fun_q),
        .ALU_OUT (alu_out)
    );

    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: round-robin instance for most steps, fixed-priority instance for priority check.
module tb_alu_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_fun, req1_fun;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [31:0] rsp_data;

    logic        fp_v0, fp_v1, fp_rsp_ready;
    logic        fp_r0, fp_r1, fp_rsp_valid, fp_rsp_id;
    logic [31:0] fp_rsp_data;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 CLK = ~CLK;

    alu_arbiter #(.RR_EN(1'b1)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_fun   (req0_fun),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_fun   (req1_fun),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
    );

    alu_arbiter #(.RR_EN(1'b0)) dut_fp (
        .CLK        (CLK),
        .RST        (RST),
        .req0_valid (fp_v0),
        .req0_ready (fp_r0),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_fun   (req0_fun),
        .req1_valid (fp_v1),
        .req1_ready (fp_r1),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_fun   (req1_fun),
        .rsp_valid  (fp_rsp_valid),
        .rsp_ready  (fp_rsp_ready),
        .rsp_data   (fp_rsp_data),
        .rsp_id     (fp_rsp_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    // Single isolated operation from one requester with rsp_ready held high.
    task automatic do_op(input string tag, input bit id, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] fun,
                         input logic [31:0] exp);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_fun = fun;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_fun = fun;
        end
        #1;
        chk({tag, "/rdy"}, 32'(id ? req1_ready : req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "/exec_valid"}, 32'(rsp_valid), 32'd0);
        tick();
        chk({tag, "/valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "/data"}, rsp_data, exp);
        chk({tag, "/id"}, 32'(rsp_id), 32'(id));
        tick();
        chk({tag, "/idle"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        RST = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        fp_v0 = 1'b0; fp_v1 = 1'b0; fp_rsp_ready = 1'b1;
        req0_a = 32'h0; req0_b = 32'h0; req0_fun = 4'h0;
        req1_a = 32'h0; req1_b = 32'h0; req1_fun = 4'h0;
        tick();
        tick();

        // Readies stay low during reset even with both requesting
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst/rdy0", 32'(req0_ready), 32'd0);
        chk("rst/rdy1", 32'(req1_ready), 32'd0);
        chk("rst/valid", 32'(rsp_valid), 32'd0);
        chk("rst/data", rsp_data, 32'd0);
        chk("rst/id", 32'(rsp_id), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        RST = 1'b0;

        do_op("single_sub", 1'b0, 32'd5, 32'd3, 4'b1000, 32'd2);

        // Round-robin tie from a fresh reset: 0,1,0,1
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_fun = 4'b0000;
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_fun = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tie/rdy0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("tie/rdy1", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk("tie/exec_rdy", 32'(req0_ready | req1_ready), 32'd0);
            tick();
            chk("tie/valid", 32'(rsp_valid), 32'd1);
            chk("tie/data", rsp_data, (i % 2 == 0) ? 32'd2 : 32'd4);
            chk("tie/id", 32'(rsp_id), 32'(i % 2));
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Backpressure with sra; requester 1 waits until the handshake completes
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h8000_0000; req0_b = 32'd4; req0_fun = 4'b1101;
        #1;
        chk("bp/rdy0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'h0000_1234; req1_b = 32'd7; req1_fun = 4'b1001;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp/valid", 32'(rsp_valid), 32'd1);
            chk("bp/data", rsp_data, 32'hF800_0000);
            chk("bp/id", 32'(rsp_id), 32'd0);
            chk("bp/rdy1", 32'(req1_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp/rdy1_hs", 32'(req1_ready), 32'd0);
        tick();
        chk("bp/after_valid", 32'(rsp_valid), 32'd0);
        chk("bp/rdy1_idle", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("copy/data", rsp_data, 32'h0000_1234);
        chk("copy/id", 32'(rsp_id), 32'd1);
        tick();

        // Fixed priority instance: requester 1 never granted
        fp_v0 = 1'b1; fp_v1 = 1'b1;
        req0_a = 32'd10; req0_b = 32'd20; req0_fun = 4'b0000;
        req1_a = 32'd1; req1_b = 32'd1; req1_fun = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fp/rdy0", 32'(fp_r0), 32'd1);
            chk("fp/rdy1", 32'(fp_r1), 32'd0);
            tick();
            chk("fp/rdy1_exec", 32'(fp_r1), 32'd0);
            tick();
            chk("fp/valid", 32'(fp_rsp_valid), 32'd1);
            chk("fp/data", fp_rsp_data, 32'd30);
            chk("fp/id", 32'(fp_rsp_id), 32'd0);
            chk("fp/rdy1_resp", 32'(fp_r1), 32'd0);
            tick();
        end
        fp_v0 = 1'b0; fp_v1 = 1'b0;

        // Reset while executing discards the operation
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd9; req0_fun = 4'b0011;
        #1;
        chk("rexec/rdy0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rexec/valid", 32'(rsp_valid), 32'd0);
            chk("rexec/data", rsp_data, 32'd0);
            chk("rexec/id", 32'(rsp_id), 32'd0);
            tick();
        end
        do_op("post_rst_sll", 1'b1, 32'd3, 32'h0000_0021, 4'b0001, 32'd6);

        do_op("illegal", 1'b0, 32'hFFFF_FFFF, 32'd1, 4'b1111, 32'd0);

        do_op("sub_wrap", 1'b0, 32'd0, 32'd1, 4'b1000, 32'hFFFF_FFFF);
        do_op("add_wrap", 1'b1, 32'hFFFF_FFFF, 32'd2, 4'b0000, 32'd1);
        do_op("slt_neg", 1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd1);
        do_op("sltu_big", 1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0011, 32'd0);
        do_op("srl", 1'b0, 32'h8000_0000, 32'h0000_0024, 4'b0101, 32'h0800_0000);
        do_op("xor", 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0100, 32'h0FF0_0FF0);
        do_op("and", 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0111, 32'hF000_F000);
        do_op("or", 1'b1, 32'hF0F0_F0F0, 32'h0000_000F, 4'b0110, 32'hF0F0_F0FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
